// File: rtl/bar_share_arb_pkg.sv
// bar_share_arb_pkg: shared types and the round-robin pick function
// for the bar datapath sharing arbiter.
package bar_share_arb_pkg;

   // Width of a requester index in a tag; bounds N_REQ to 64.
   localparam int IDXW    = 6;
   localparam int MAX_REQ = 1 << IDXW;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_e;

   typedef struct packed {
      logic            vld;
      logic [IDXW-1:0] idx;
   } tag_t;

   // One-hot winner: first set bit of valid at or after ptr, wrapping at n.
   function automatic logic [MAX_REQ-1:0] rr_pick(
      input logic [MAX_REQ-1:0] valid,
      input logic [IDXW-1:0]    ptr,
      input int                 n
   );
      logic [MAX_REQ-1:0] pick;
      logic               found;
      int                 pos;
      logic [IDXW-1:0]    ix;
      pick  = '0;
      found = 1'b0;
      for (int k = 0; k < MAX_REQ; k++) begin
         if (k < n && !found) begin
            pos = int'(ptr) + k;
            if (pos >= n) pos = pos - n;
            ix = pos[IDXW-1:0];
            if (valid[ix]) begin
               pick[ix] = 1'b1;
               found    = 1'b1;
            end
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/bar_share_arb_tagpipe.sv
// bar_share_arb_tagpipe: LAT+1 stage tag shift register that follows each
// issued operation through the bar pipeline, plus the in-flight counter.
module bar_share_arb_tagpipe
   import bar_share_arb_pkg::*;
#(
   parameter int LAT = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  tag_t                     in_tag,
   output tag_t                     out_tag,
   output logic [$clog2(LAT+2)-1:0] cnt,
   output logic [$clog2(LAT+2)-1:0] cnt_nxt
);

   localparam int CW = $clog2(LAT+2);

   tag_t pipe [LAT+1];

   // Shift tags one stage per cycle; stage LAT lines up with bar_rvalid.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k <= LAT; k++) pipe[k] <= '0;
      end else begin
         pipe[0] <= in_tag;
         for (int k = 1; k <= LAT; k++) pipe[k] <= pipe[k-1];
      end
   end

   assign out_tag = pipe[LAT];

   // Count up on entry, down on retirement; both at once cancel.
   always_comb begin
      cnt_nxt = cnt;
      case ({in_tag.vld, out_tag.vld})
         2'b10:   cnt_nxt = cnt + CW'(1);
         2'b01:   cnt_nxt = cnt - CW'(1);
         default: cnt_nxt = cnt;
      endcase
   end

   // In-flight count register.
   always_ff @(posedge clk) begin
      if (rst) cnt <= '0;
      else     cnt <= cnt_nxt;
   end

endmodule

// File: rtl/bar_share_arb.sv
// bar_share_arb: round-robin sharing of one fixed-latency bar unit among
// N_REQ requesters, with results routed back to the issuing requester.
// Optional per-requester grant counters under `BAR_SHARE_ARB_PERF_EN`.
//
// state | meaning
// IDLE  | arbitration off, nothing in flight
// RUN   | granting one request per cycle while en is high
// DRAIN | en dropped, waiting for in-flight operations to return
module bar_share_arb
   import bar_share_arb_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int DW    = 16,
   parameter int SW    = 8,
   parameter int LAT   = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic [N_REQ-1:0]      req_valid,
   input  logic [N_REQ*DW-1:0]   req_p,
   input  logic [N_REQ-1:0]      req_q,
   output logic [N_REQ-1:0]      req_ready,
   output logic                  bar_valid,
   output logic [DW-1:0]         bar_p,
   output logic                  bar_q,
   input  logic                  bar_rvalid,
   input  logic [DW-1:0]         bar_r,
   input  logic [SW-1:0]         bar_s,
   output logic [N_REQ-1:0]      rsp_valid,
   output logic [DW-1:0]         rsp_r,
   output logic [SW-1:0]         rsp_s,
   output logic                  busy,
   output logic                  err
`ifdef BAR_SHARE_ARB_PERF_EN
   ,
   input  logic [$clog2(N_REQ)-1:0] perf_sel,
   output logic [31:0]              perf_cnt
`endif
);

   localparam int PW = $clog2(N_REQ);
   localparam int CW = $clog2(LAT+2);

   state_e           state, state_nxt;
   logic [PW-1:0]    ptr;
   logic [PW-1:0]    win;
   logic [N_REQ-1:0] grant;
   logic             hs;
   tag_t             in_tag, out_tag;
   logic [CW-1:0]    cnt, cnt_nxt;

   // Grant the round-robin winner, only while running with en high.
   always_comb begin
      grant = '0;
      if (state == RUN && en)
         grant = N_REQ'(rr_pick(MAX_REQ'(req_valid), IDXW'(ptr), N_REQ));
      win = '0;
      for (int i = 0; i < N_REQ; i++)
         if (grant[i]) win = PW'(i);
      hs = |(grant & req_valid);
   end

   assign req_ready = grant;

   // Pointer moves just past the winner on every handshake.
   always_ff @(posedge clk) begin
      if (rst)     ptr <= '0;
      else if (hs) ptr <= (win == PW'(N_REQ-1)) ? '0 : win + PW'(1);
   end

   // Register the winner's operands onto the bar issue port.
   always_ff @(posedge clk) begin
      if (rst) begin
         bar_valid <= 1'b0;
         bar_p     <= '0;
         bar_q     <= 1'b0;
      end else begin
         bar_valid <= hs;
         bar_p     <= hs ? req_p[win*DW +: DW] : '0;
         bar_q     <= hs ? req_q[win] : 1'b0;
      end
   end

   assign in_tag = '{vld: hs, idx: IDXW'(win)};

   bar_share_arb_tagpipe #(.LAT(LAT)) u_tagpipe (
      .clk     (clk),
      .rst     (rst),
      .in_tag  (in_tag),
      .out_tag (out_tag),
      .cnt     (cnt),
      .cnt_nxt (cnt_nxt)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Leave RUN/DRAIN as the last tag retires so busy and IDLE line up.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (en) state_nxt = RUN;
         RUN:     if (!en) state_nxt = (cnt_nxt == '0) ? IDLE : DRAIN;
         DRAIN:   if (cnt_nxt == '0) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign busy = (state != IDLE) || (cnt != '0);

   // Return a result to its owner when the expected tag and strobe coincide.
   always_ff @(posedge clk) begin
      if (rst) begin
         rsp_valid <= '0;
         rsp_r     <= '0;
         rsp_s     <= '0;
      end else if (out_tag.vld && bar_rvalid) begin
         rsp_valid <= N_REQ'(1) << out_tag.idx;
         rsp_r     <= bar_r;
         rsp_s     <= bar_s;
      end else begin
         rsp_valid <= '0;
         rsp_r     <= '0;
         rsp_s     <= '0;
      end
   end

   // Sticky error on a missing result or an unexpected result strobe.
   always_ff @(posedge clk) begin
      if (rst)                           err <= 1'b0;
      else if (out_tag.vld != bar_rvalid) err <= 1'b1;
   end

`ifdef BAR_SHARE_ARB_PERF_EN
   logic [31:0] gnt_cnt [N_REQ];

   // Saturating grant counters and a registered read port.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < N_REQ; i++) gnt_cnt[i] <= '0;
         perf_cnt <= '0;
      end else begin
         for (int i = 0; i < N_REQ; i++)
            if (hs && win == PW'(i) && gnt_cnt[i] != 32'hFFFF_FFFF)
               gnt_cnt[i] <= gnt_cnt[i] + 32'd1;
         perf_cnt <= (int'(perf_sel) < N_REQ) ? gnt_cnt[perf_sel] : '0;
      end
   end
`endif

endmodule

// File: tb/tb_bar_share_arb.sv
// tb_bar_share_arb: directed stimulus with a grant/response scoreboard
// and a behavioural bar model of latency LAT.
module tb_bar_share_arb;

   localparam int N   = 4;
   localparam int DW  = 16;
   localparam int SW  = 8;
   localparam int LAT = 2;

   logic            clk = 1'b0;
   logic            rst, en;
   logic [N-1:0]    req_valid, req_q, req_ready, rsp_valid;
   logic [N*DW-1:0] req_p;
   logic            bar_valid, bar_q, bar_rvalid, busy, err;
   logic [DW-1:0]   bar_p, bar_r, rsp_r;
   logic [SW-1:0]   bar_s, rsp_s;
`ifdef BAR_SHARE_ARB_PERF_EN
   logic [1:0]      perf_sel;
   logic [31:0]     perf_cnt;
`endif

   always #5 clk = ~clk;

   bar_share_arb #(.N_REQ(N), .DW(DW), .SW(SW), .LAT(LAT)) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .req_valid  (req_valid),
      .req_p      (req_p),
      .req_q      (req_q),
      .req_ready  (req_ready),
      .bar_valid  (bar_valid),
      .bar_p      (bar_p),
      .bar_q      (bar_q),
      .bar_rvalid (bar_rvalid),
      .bar_r      (bar_r),
      .bar_s      (bar_s),
      .rsp_valid  (rsp_valid),
      .rsp_r      (rsp_r),
      .rsp_s      (rsp_s),
      .busy       (busy),
      .err        (err)
`ifdef BAR_SHARE_ARB_PERF_EN
      ,
      .perf_sel   (perf_sel),
      .perf_cnt   (perf_cnt)
`endif
   );

   function automatic logic [DW-1:0] model_r(logic [DW-1:0] p, logic q);
      return p ^ (q ? 16'hACDB : 16'h0000);
   endfunction

   function automatic logic [SW-1:0] model_s(logic [DW-1:0] p, logic q);
      return p[7:0] ^ (q ? 8'h6E : 8'h00);
   endfunction

   // bar model: LAT-deep pipeline; drop_en swallows issues, stray injects a strobe
   logic          mv [LAT];
   logic [DW-1:0] mp [LAT];
   logic          mq [LAT];
   logic          drop_en = 1'b0;
   logic          stray   = 1'b0;

   always @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < LAT; k++) begin
            mv[k] <= 1'b0; mp[k] <= '0; mq[k] <= 1'b0;
         end
      end else begin
         mv[0] <= bar_valid & ~drop_en;
         mp[0] <= bar_p;
         mq[0] <= bar_q;
         for (int k = 1; k < LAT; k++) begin
            mv[k] <= mv[k-1]; mp[k] <= mp[k-1]; mq[k] <= mq[k-1];
         end
      end
   end

   assign bar_rvalid = mv[LAT-1] | stray;
   assign bar_r      = mv[LAT-1] ? model_r(mp[LAT-1], mq[LAT-1]) : '0;
   assign bar_s      = mv[LAT-1] ? model_s(mp[LAT-1], mq[LAT-1]) : '0;

   typedef struct {
      int            idx;
      logic [DW-1:0] r;
      logic [SW-1:0] s;
   } rsp_t;

   rsp_t exp_rsp [$];
   int   exp_gnt [$];
   int   hs_cyc  [$];
   int   cyc = 0;
   int   vectors = 0;
   int   miscompares = 0;

   int       mon_g, mon_h;
   rsp_t     mon_e;
   logic [N-1:0] mon_oh;

   // Monitor: pops expected grants and responses as the DUT presents them.
   always @(negedge clk) begin
      cyc++;
      if (!rst && (req_valid & req_ready) != '0) begin
         vectors++;
         if (exp_gnt.size() == 0) begin
            miscompares++;
            $display("FAIL grant: unexpected handshake req_ready=%b", req_ready);
         end else begin
            mon_g  = exp_gnt.pop_front();
            mon_oh = N'(1) << mon_g;
            if (req_ready !== mon_oh) begin
               miscompares++;
               $display("FAIL grant: req_ready=%b expected %b", req_ready, mon_oh);
            end
         end
         hs_cyc.push_back(cyc);
      end
      if (rsp_valid != '0) begin
         vectors++;
         if (exp_rsp.size() == 0) begin
            miscompares++;
            $display("FAIL rsp: unexpected rsp_valid=%b r=%h s=%h", rsp_valid, rsp_r, rsp_s);
         end else begin
            mon_e  = exp_rsp.pop_front();
            mon_oh = N'(1) << mon_e.idx;
            if (rsp_valid !== mon_oh || rsp_r !== mon_e.r || rsp_s !== mon_e.s) begin
               miscompares++;
               $display("FAIL rsp: got v=%b r=%h s=%h expected v=%b r=%h s=%h",
                        rsp_valid, rsp_r, rsp_s, mon_oh, mon_e.r, mon_e.s);
            end
            if (hs_cyc.size() != 0) begin
               mon_h = hs_cyc.pop_front();
               vectors++;
               if (cyc != mon_h + 2 + LAT) begin
                  miscompares++;
                  $display("FAIL latency: rsp at cycle %0d expected %0d", cyc, mon_h + 2 + LAT);
               end
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_gnt(input int bound, output int n);
      n = 0;
      while (exp_gnt.size() != 0 && n < bound) begin
         @(negedge clk);
         #2;
         n++;
      end
      check("grant queue drained", exp_gnt.size(), 0);
   endtask

   task automatic wait_rsp(input int bound);
      int n;
      n = 0;
      while (exp_rsp.size() != 0 && n < bound) begin
         tick();
         n++;
      end
      check("response queue drained", exp_rsp.size(), 0);
   endtask

   task automatic push_op(input int idx, input logic [DW-1:0] r, input logic [SW-1:0] s);
      rsp_t t;
      t.idx = idx; t.r = r; t.s = s;
      exp_gnt.push_back(idx);
      exp_rsp.push_back(t);
   endtask

   logic [DW-1:0] p_tab [N];

   initial begin
      int n;
      p_tab[0] = 16'h1111; p_tab[1] = 16'h2222;
      p_tab[2] = 16'h3333; p_tab[3] = 16'h4444;
      rst = 1'b1; en = 1'b0; req_valid = '0; req_p = '0; req_q = '0;
`ifdef BAR_SHARE_ARB_PERF_EN
      perf_sel = '0;
`endif
      repeat (3) tick();
      check("reset req_ready", req_ready, 0);
      check("reset bar_valid", bar_valid, 0);
      check("reset bar_p", bar_p, 0);
      check("reset rsp_valid", rsp_valid, 0);
      check("reset rsp_r", rsp_r, 0);
      check("reset busy", busy, 0);
      check("reset err", err, 0);
      rst = 1'b0;
      tick();

      // fairness: all four valid, two rounds
      for (int i = 0; i < N; i++) begin
         req_p[i*DW +: DW] = p_tab[i];
         req_q[i]          = 1'(i & 1);
      end
      for (int rep = 0; rep < 2; rep++)
         for (int i = 0; i < N; i++)
            push_op(i, model_r(p_tab[i], 1'(i & 1)), model_s(p_tab[i], 1'(i & 1)));
      en = 1'b1;
      req_valid = 4'hF;
      wait_gnt(30, n);
      tick();
      req_valid = '0;
      wait_rsp(30);

      // data routing through requester 2
      req_p[2*DW +: DW] = 16'h1234;
      req_q[2]          = 1'b1;
      push_op(2, 16'hBEEF, 8'h5A);
      req_valid = 4'b0100;
      wait_gnt(20, n);
      tick();
      req_valid = '0;
      wait_rsp(20);

      // single requester granted every cycle
      req_p[1*DW +: DW] = 16'h00F0;
      req_q[1]          = 1'b0;
      for (int k = 0; k < 3; k++) push_op(1, 16'h00F0, 8'hF0);
      req_valid = 4'b0010;
      wait_gnt(20, n);
      check("back-to-back grant cycles", n, 3);
      tick();
      req_valid = '0;
      wait_rsp(20);

      // drain: three ops (2,3,0) then en low with requests still pending
      push_op(2, 16'hBEEF, 8'h5A);
      push_op(3, 16'hE89F, 8'h2A);
      push_op(0, 16'h1111, 8'h11);
      req_valid = 4'hF;
      wait_gnt(20, n);
      tick();
      en = 1'b0;
      check("drain busy high", busy, 1);
      wait_rsp(20);
      n = 0;
      while (busy && n < 20) begin tick(); n++; end
      check("drain busy low", busy, 0);
      repeat (3) tick();
      req_valid = '0;

      // error: suppressed result
      check("err clear before drop", err, 0);
      en = 1'b1;
      drop_en = 1'b1;
      exp_gnt.push_back(1);
      req_valid = 4'b0010;
      wait_gnt(20, n);
      tick();
      req_valid = '0;
      repeat (8) tick();
      check("err after dropped result", err, 1);
      drop_en = 1'b0;
      hs_cyc.delete();
      push_op(2, 16'hBEEF, 8'h5A);
      req_valid = 4'b0100;
      wait_gnt(20, n);
      tick();
      req_valid = '0;
      wait_rsp(20);
      check("err sticky", err, 1);

      // error: stray strobe with nothing in flight
      en = 1'b0;
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      tick();
      check("err cleared by reset", err, 0);
      stray = 1'b1;
      tick();
      stray = 1'b0;
      tick();
      check("err after stray strobe", err, 1);

      // reset mid-flight
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      en = 1'b1;
      exp_gnt.push_back(0);
      exp_gnt.push_back(1);
      req_valid = 4'b0011;
      wait_gnt(20, n);
      tick();
      req_valid = '0;
      en = 1'b0;
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      hs_cyc.delete();
      repeat (8) tick();
      check("post-reset req_ready", req_ready, 0);
      check("post-reset bar_valid", bar_valid, 0);
      check("post-reset bar_p", bar_p, 0);
      check("post-reset rsp_valid", rsp_valid, 0);
      check("post-reset busy", busy, 0);
      check("post-reset err", err, 0);
      en = 1'b1;
      push_op(0, 16'h1111, 8'h11);
      req_valid = 4'hF;
      wait_gnt(20, n);
      tick();
      req_valid = '0;
      wait_rsp(20);

`ifdef BAR_SHARE_ARB_PERF_EN
      for (int k = 0; k < 10; k++) push_op(1, 16'h00F0, 8'hF0);
      req_valid = 4'b0010;
      wait_gnt(30, n);
      tick();
      req_valid = '0;
      wait_rsp(30);
      perf_sel = 2'd1;
      tick(); tick();
      check("perf_cnt requester 1", perf_cnt, 10);
      perf_sel = 2'd0;
      tick(); tick();
      check("perf_cnt requester 0", perf_cnt, 1);
`endif

      en = 1'b0;
      repeat (4) tick();
      check("no leftover responses", exp_rsp.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule
